video_timing_gen: RTL

Parametrised successor to the fixed 640x480 HDMI debug timing generator. Produces HSYNC/VSYNC/DE for any VESA-style timing, issues a memory read strobe a configurable number of cycles ahead of DE, and drives pixel data in one of three runtime-selectable modes. It sits between the frame-buffer read port and the HDMI encoder's parallel pixel input, and exposes frame statistics for debug.

---
 rtl/vtg_pkg.sv | 35 +++
 rtl/vtg_counter.sv | 23 ++
 rtl/video_timing_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vtg_pkg.sv
// Shared definitions for the video timing generator: pixel mode encodings,
// colour-bar palette and the line/frame total helper.
package vtg_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_BARS    = 2'd2,
        MODE_BLACK   = 2'd3
    } vtg_mode_e;

    // 8-bit-per-component RGB, red in the top byte; the top uses only each
    // component's MSB and replicates it to DATA_W/3 bits.
    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    localparam logic [7:0][23:0] BAR_COLOURS = {
        BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
        BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE
    };

    function automatic int unsigned vtg_total(input int unsigned sync_w,
                                              input int unsigned bp,
                                              input int unsigned act,
                                              input int unsigned fp);
        return sync_w + bp + act + fp;
    endfunction

endpackage

// File: rtl/vtg_counter.sv
// Wrap counter 0..LAST with enable and a configurable async reset value.
module vtg_counter #(
    parameter int          W       = 16,
    parameter int unsigned LAST    = 799,
    parameter int unsigned RST_VAL = LAST
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(LAST));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= W'(RST_VAL);
        else if (en)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised VESA-style timing generator with lead-time read strobe and
// runtime pixel modes. Colour bars are compiled only with VTG_PATTERN_EN.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LEAD  = 3,
    parameter bit SYNC_ACT = 1'b0,
    parameter int DATA_W   = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        mode,
    input  logic              frame_parity,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_empty,
    input  logic              clr_stat,
    output logic              mem_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_de,
    output logic              frame_start,
    output logic [15:0]       pixel_x,
    output logic [15:0]       pixel_y,
    output logic [15:0]       underrun_cnt
);

    localparam int H_TOTAL = int'(vtg_total(H_SYNC, H_BP, H_ACTIVE, H_FP));
    localparam int V_TOTAL = int'(vtg_total(V_SYNC, V_BP, V_ACTIVE, V_FP));

    localparam logic [15:0] HS_END  = 16'(H_SYNC);
    localparam logic [15:0] VS_END  = 16'(V_SYNC);
    localparam logic [15:0] HA0     = 16'(H_SYNC + H_BP);
    localparam logic [15:0] HA1     = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [15:0] VA0     = 16'(V_SYNC + V_BP);
    localparam logic [15:0] VA1     = 16'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [15:0] RD0     = 16'(H_SYNC + H_BP - RD_LEAD);
    localparam logic [15:0] RD1     = 16'(H_SYNC + H_BP + H_ACTIVE - RD_LEAD);
    localparam logic [15:0] PX_LAST = 16'(H_ACTIVE - 1);

    logic [15:0] h_cnt, v_cnt;
    logic        h_wrap, v_wrap;
    logic        h_act, v_act, rd_win, at_origin;
    logic        line_par;
    vtg_mode_e   mode_q;
    logic [15:0] stat_cnt;

    vtg_counter #(.W(16), .LAST(H_TOTAL - 1), .RST_VAL(H_TOTAL - 1)) u_hcnt (
        .clk(clk), .rstn(rstn), .en(1'b1), .cnt(h_cnt), .wrap(h_wrap)
    );

    vtg_counter #(.W(16), .LAST(V_TOTAL - 1), .RST_VAL(V_TOTAL - 1)) u_vcnt (
        .clk(clk), .rstn(rstn), .en(h_wrap), .cnt(v_cnt), .wrap(v_wrap)
    );

    assign h_act     = (h_cnt >= HA0) && (h_cnt < HA1);
    assign v_act     = (v_cnt >= VA0) && (v_cnt < VA1);
    // The read window is the active window moved RD_LEAD clocks earlier in the same line.
    assign rd_win    = (h_cnt >= RD0) && (h_cnt < RD1);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_hsync   <= ~SYNC_ACT;
            out_vsync   <= ~SYNC_ACT;
            out_de      <= 1'b0;
            mem_rd      <= 1'b0;
            frame_start <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            mode_q      <= MODE_PASS;
            line_par    <= 1'b0;
        end else begin
            out_hsync   <= (h_cnt < HS_END) ? SYNC_ACT : ~SYNC_ACT;
            out_vsync   <= (v_cnt < VS_END) ? SYNC_ACT : ~SYNC_ACT;
            out_de      <= h_act && v_act;
            mem_rd      <= rd_win && v_act;
            frame_start <= at_origin;
            pixel_x     <= (h_act && v_act) ? h_cnt - HA0 : '0;
            pixel_y     <= (h_act && v_act) ? v_cnt - VA0 : '0;
            if (at_origin) begin
                mode_q   <= vtg_mode_e'(mode);
                line_par <= frame_parity;
            end else if (out_de && pixel_x == PX_LAST) begin
                line_par <= ~line_par;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stat_cnt <= '0;
        else if (clr_stat)
            stat_cnt <= '0;
        else if (mem_rd && mem_empty && stat_cnt != 16'hFFFF)
            stat_cnt <= stat_cnt + 16'd1;
    end

    assign underrun_cnt = stat_cnt;

    logic [DATA_W-1:0] bar_px;
`ifdef VTG_PATTERN_EN
    localparam int CW = DATA_W / 3;
    logic [2:0] bar_idx;
    assign bar_idx = 3'((32'(pixel_x) * 32'd8) / 32'(H_ACTIVE));
    for (genvar c = 0; c < 3; c++) begin : g_comp
        assign bar_px[c*CW +: CW] = {CW{BAR_COLOURS[bar_idx][c*8 + 7]}};
    end
`else
    assign bar_px = '0;
`endif

    // mem_data arrives aligned with out_de, so the final mux is combinational.
    always_comb begin
        out_data = '0;
        if (out_de) begin
            case (mode_q)
                MODE_PASS:    out_data = mem_data;
                MODE_CHECKER: if (pixel_x[0] == line_par) out_data = mem_data;
                MODE_BARS:    out_data = bar_px;
                default:      out_data = '0;
            endcase
        end
    end

    logic unused;
    assign unused = v_wrap;

endmodule
